// File: rtl/snn_sched_if.sv
// Handshake bundle between the SNN inference scheduler, its config registers and the layer datapath.
interface snn_sched_if #(
    parameter int NUM_LAYERS  = 1,
    parameter int NUM_OUTPUTS = 2,
    parameter int STEP_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int WIN_WIDTH   = 1
) ();
    logic                             start;
    logic                             abort;
    logic [STEP_WIDTH-1:0]            num_steps;
    logic                             busy;
    logic                             done;
    logic                             net_clear;
    logic                             input_load;
    logic                             input_ack;
    logic [NUM_LAYERS:0]              layer_go;
    logic                             layer_done;
    logic [NUM_OUTPUTS-1:0]           out_spikes;
    logic [STEP_WIDTH-1:0]            step_count;
    logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_count;
    logic [WIN_WIDTH-1:0]             winner;
    logic                             winner_valid;

    // Host/datapath side.
    modport master (
        output start, abort, num_steps, input_ack, layer_done, out_spikes,
        input  busy, done, net_clear, input_load, layer_go,
        input  step_count, spike_count, winner, winner_valid
    );

    // Scheduler side.
    modport slave (
        input  start, abort, num_steps, input_ack, layer_done, out_spikes,
        output busy, done, net_clear, input_load, layer_go,
        output step_count, spike_count, winner, winner_valid
    );
endinterface

// File: rtl/snn_inference_scheduler.sv
// Runs one SNN inference over num_steps timesteps, firing each layer stage in order,
// counting output spikes per neuron and reporting the arg-max winner.
module snn_inference_scheduler #(
    parameter int NUM_LAYERS  = 1,
    parameter int NUM_OUTPUTS = 2,
    parameter int STEP_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int WIN_WIDTH   = 1
) (
    input logic        S_AXI_ACLK,
    input logic        S_AXI_ARESET,
    snn_sched_if.slave bus
);
    localparam int STAGES  = NUM_LAYERS + 1;
    localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_GO       = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_STEP_END = 3'd5;
    localparam logic [2:0] S_ARGMAX   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]            state;
    logic [STEP_WIDTH-1:0] steps_lat;
    logic [STEP_WIDTH-1:0] step_cnt;
    logic [STEP_WIDTH-1:0] step_next;
    logic [STAGE_W-1:0]    stage;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      win_idx;
    logic [CNT_WIDTH-1:0]  cnt [NUM_OUTPUTS];
    logic                  win_vld;
    logic                  aborting;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign aborting  = bus.abort && (state != S_IDLE);
    assign step_next = step_cnt + STEP_WIDTH'(1);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state     <= S_IDLE;
            steps_lat <= '0;
            step_cnt  <= '0;
            stage     <= '0;
            scan_idx  <= '0;
            win_idx   <= '0;
            win_vld   <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
        end else if (aborting) begin
            // Counts and step_count deliberately keep their partial values.
            state   <= S_IDLE;
            win_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        steps_lat <= bus.num_steps;
                        win_vld   <= 1'b0;
                        if (bus.num_steps != '0) begin
                            state <= S_CLEAR;
                        end else begin
                            step_cnt <= '0;
                            for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
                            win_idx  <= '0;
                            scan_idx <= IDX_W'(1);
                            state    <= S_ARGMAX;
                        end
                    end
                end
                S_CLEAR: begin
                    step_cnt <= '0;
                    for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (bus.input_ack) begin
                        stage <= '0;
                        state <= S_GO;
                    end
                end
                S_GO: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.layer_done) begin
                        if (stage != STAGE_W'(NUM_LAYERS)) begin
                            stage <= stage + STAGE_W'(1);
                            state <= S_GO;
                        end else begin
                            for (int i = 0; i < NUM_OUTPUTS; i++)
                                if (bus.out_spikes[i]) cnt[i] <= sat_inc(cnt[i]);
                            state <= S_STEP_END;
                        end
                    end
                end
                S_STEP_END: begin
                    step_cnt <= step_next;
                    if (step_next == steps_lat) begin
                        win_idx  <= '0;
                        scan_idx <= IDX_W'(1);
                        state    <= S_ARGMAX;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_ARGMAX: begin
                    // Strictly-greater replacement keeps ties on the lowest index.
                    if (NUM_OUTPUTS > 1) begin
                        if (cnt[scan_idx] > cnt[win_idx]) win_idx <= scan_idx;
                        if (scan_idx == IDX_W'(NUM_OUTPUTS - 1)) begin
                            win_vld <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end else begin
                        win_vld <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by abort so they drop in the very cycle abort arrives.
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE) && !bus.abort;
    assign bus.net_clear    = (state == S_CLEAR) && !bus.abort;
    assign bus.input_load   = (state == S_LOAD) && !bus.abort;
    assign bus.layer_go     = ((state == S_GO) && !bus.abort) ? (STAGES'(1) << stage) : '0;
    assign bus.step_count   = step_cnt;
    assign bus.winner       = WIN_WIDTH'(win_idx);
    assign bus.winner_valid = win_vld && !aborting;

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_cnt
        assign bus.spike_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt[gi];
    end
endmodule

// File: tb/tb_snn_inference_scheduler.sv
// Scoreboard bench: a default instance and a 2-bit-counter instance run in lockstep on shared stimulus.
module tb_snn_inference_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_steps;
    logic        input_ack;
    logic        layer_done;
    logic [1:0]  out_spikes;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] pat [0:7];

    typedef struct {
        int c0; int c1; int s0; int s1; int win; int swin; int steps;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    snn_sched_if #(.CNT_WIDTH(16)) bus0 ();
    snn_sched_if #(.CNT_WIDTH(2))  bus1 ();

    assign bus0.start      = start;
    assign bus0.abort      = abort;
    assign bus0.num_steps  = num_steps;
    assign bus0.input_ack  = input_ack;
    assign bus0.layer_done = layer_done;
    assign bus0.out_spikes = out_spikes;
    assign bus1.start      = start;
    assign bus1.abort      = abort;
    assign bus1.num_steps  = num_steps;
    assign bus1.input_ack  = input_ack;
    assign bus1.layer_done = layer_done;
    assign bus1.out_spikes = out_spikes;

    snn_inference_scheduler #(.CNT_WIDTH(16)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus0)
    );

    snn_inference_scheduler #(.CNT_WIDTH(2)) dut_sat (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // mode 0: normal run (with an ignored start mid-run); 1: abort in WAIT of step 2; 2: abort in GO of step 2
    task automatic run(input int n, input int mode);
        exp_t e;
        int   step, stage, cycles, clears, gos, dones;
        bit   ack_pend, go_pend, injected, ended;
        e = '{default: 0};
        for (int s = 0; s < n; s++) begin
            e.c0 += int'(pat[s][0]);
            e.c1 += int'(pat[s][1]);
            if (pat[s][0] && e.s0 < 3) e.s0++;
            if (pat[s][1] && e.s1 < 3) e.s1++;
        end
        e.win   = (e.c1 > e.c0) ? 1 : 0;
        e.swin  = (e.s1 > e.s0) ? 1 : 0;
        e.steps = n;
        if (mode == 0) sb.push_back(e);

        @(negedge clk);
        num_steps = 16'(n);
        start     = 1'b1;
        @(negedge clk);
        num_steps = 16'd9;
        check("wv_cleared_on_start", bus0.winner_valid, 0);
        step = 0; stage = 0; cycles = 0; clears = 0; gos = 0; dones = 0;
        ack_pend = 0; go_pend = 0; injected = 0; ended = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            start = 1'b0; abort = 1'b0; input_ack = 1'b0; layer_done = 1'b0;
            if (!bus0.busy) begin
                ended = 1;
                break;
            end
            cycles++;
            if (bus0.net_clear) clears++;
            if (bus0.done) begin
                exp_t p;
                dones++;
                check("sb_not_empty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    p = sb.pop_front();
                    check("wv_with_done", bus0.winner_valid, 1);
                    check("spike_count", bus0.spike_count, (64'(p.c1) << 16) | 64'(p.c0));
                    check("winner", bus0.winner, p.win);
                    check("step_count", bus0.step_count, p.steps);
                    check("sat_spike_count", bus1.spike_count, (64'(p.s1) << 2) | 64'(p.s0));
                    check("sat_winner", bus1.winner, p.swin);
                end
            end
            if (bus0.input_load) begin
                if (ack_pend) begin
                    input_ack = 1'b1;
                    ack_pend  = 0;
                end else begin
                    ack_pend = 1;
                end
                if (mode == 0 && step == 1 && !injected) begin
                    start     = 1'b1;
                    num_steps = 16'd7;
                    injected  = 1;
                end
            end
            if (go_pend) begin
                go_pend = 0;
                if (mode == 1 && step == 1) begin
                    abort = 1'b1;
                end else begin
                    layer_done = 1'b1;
                    if (stage == 1) begin
                        out_spikes = pat[step];
                        step++;
                        stage = 0;
                    end else begin
                        stage++;
                    end
                end
            end
            if (bus0.layer_go != 2'b00) begin
                gos++;
                check("layer_go_onehot", bus0.layer_go, 64'(1) << stage);
                go_pend = 1;
                if (mode == 2 && step == 1) begin
                    abort = 1'b1;
                    #1;
                    check("layer_go_drops_on_abort", bus0.layer_go, 0);
                end
            end
            @(negedge clk);
        end
        check("run_terminates", ended, 1);
        check("busy_after", bus0.busy, 0);
        if (mode == 0) begin
            check("done_pulses", dones, 1);
            check("net_clear_pulses", clears, (n > 0) ? 1 : 0);
            check("layer_go_strobes", gos, 2 * n);
            check("busy_cycles", cycles, (n > 0) ? 7 * n + 3 : 2);
            check("wv_holds", bus0.winner_valid, 1);
        end else begin
            check("abort_no_done", dones, 0);
            check("abort_wv", bus0.winner_valid, 0);
            check("abort_layer_go", bus0.layer_go, 0);
            check("abort_input_load", bus0.input_load, 0);
            check("abort_step_hold", bus0.step_count, 1);
            check("abort_count_hold", bus0.spike_count,
                  (64'(pat[0][1]) << 16) | 64'(pat[0][0]));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0;
        input_ack = 1'b0; layer_done = 1'b0; out_spikes = 2'b00;
        for (int i = 0; i < 8; i++) pat[i] = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_strobes", {bus0.net_clear, bus0.input_load, bus0.layer_go}, 0);
        check("rst_counts", {bus0.step_count, bus0.spike_count}, 0);
        check("rst_winner", {bus0.winner, bus0.winner_valid}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) pat[i] = 2'b01;
        run(3, 0);
        pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b11;
        run(4, 0);
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
        run(4, 0);
        for (int i = 0; i < 8; i++) pat[i] = 2'b11;
        run(5, 0);
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11;
        run(3, 1);
        run(3, 2);
        run(3, 0);
        run(0, 0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
